dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
- Round-robin arbiter that shares one single-port synchronous data memory among N_CORES matrix-multiplication cores.
- Each core issues one read or write request and holds it until acknowledged. The arbiter serialises requests onto the memory port and returns read data with a one-cycle ack pulse.
- Sits between the cores' data-memory ports (write enable, 8-bit address, 16-bit data) and the shared data RAM.

Parameters:
- N_CORES, 4, number of requesting cores (2..8)
- ADDR_W, 8, data memory address width
- DATA_W, 16, data word width

Ports:
- clock  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- core_req  in  N_CORES  per-core request; held high until that core's ack
- core_we  in  N_CORES  per-core write (1) / read (0); stable while req high
- core_addr  in  N_CORES*ADDR_W  packed per-core address, core c at [c*ADDR_W +: ADDR_W]
- core_wdata  in  N_CORES*DATA_W  packed per-core write data
- core_ack  out  N_CORES  one-hot, one-cycle completion pulse
- core_rdata  out  DATA_W  read data, valid in the cycle core_ack is high
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, winner=0. core_ack, core_rdata, mem_en, mem_we, mem_addr and mem_wdata all drive 0; busy=0.
- States: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - If any core_req is high, select the winner: the first requesting index at or after rr_ptr, searching cyclically upward. Register winner and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (one cycle):
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the winner's inputs, all registered outputs.
  - Go to RESP.
- RESP (one cycle):
  - core_ack[winner]=1; core_rdata is mem_rdata captured into a register at the end of the ISSUE-to-RESP edge.
  - Write accesses also ack, with core_rdata=0.
  - rr_ptr <= (winner+1) mod N_CORES; go to IDLE.
- Latency: req seen high at cycle 0 (IDLE) -> mem_en at cycle 1 -> ack at cycle 2. Peak throughput is one access per 3 cycles.
- Core obligation: deassert req in the cycle after ack, or re-assert it for a new access. The arbiter never re-grants a core during its ack cycle, because IDLE re-arbitrates with the updated rr_ptr.
- Fairness: a continuously requesting core is granted within N_CORES grants of any other core.
- Requests that change or drop while not granted are ignored without error.
- A req deasserted after its grant does not cancel the access; the ack is still issued.
- Simultaneous requests: exactly one grant per arbitration; the others wait in priority order.
- rr_ptr wraps from N_CORES-1 to 0.
- Reset mid-access: outputs clear immediately, so a write in ISSUE is not committed if rst_n falls before the clock edge. No ack is issued; the core must re-request.
- core_ack is never multi-hot. mem_en is never high in two consecutive cycles.

Decomposition:
- Shared package dm_arb_pkg:
  - state encoding: IDLE=2'd0, ISSUE=2'd1, RESP=2'd2
  - default ADDR_W and DATA_W constants
  - function clog2 for the winner and rr_ptr width
- One combinational sub-module, rr_pick:
  - inputs: req vector and start pointer
  - outputs: winner index and any_req
  - implemented as a doubled-vector priority scan; reused by future arbiters (e.g. instruction memory).

Test Plan:
- Single read: core 2 reads addr 0x10 (RAM holds 0x1234) -> mem_en at cycle 1 with mem_addr=0x10, mem_we=0; core_ack=4'b0100 with core_rdata=0x1234 at cycle 2.
- Single write: core 0 writes 0xBEEF to 0x05 -> mem_we=1, mem_wdata=0xBEEF at cycle 1; ack 4'b0001 at cycle 2; a later read of 0x05 returns 0xBEEF.
- All four cores request continuously from reset -> grant order 0,1,2,3,0; acks 3 cycles apart; never two acks in one cycle.
- Cores 1 and 3 request after core 3 was last served -> core 0 is skipped (no req), core 1 is granted first, then core 3.
- rst_n pulled low during ISSUE of a write to 0x20 -> mem_en/mem_we drop immediately, 0x20 is unchanged, no ack; after release a new request from core 0 is granted first.
- Winner drops req during ISSUE -> ack is still issued at RESP, and the next arbitration starts from winner+1.

Source files
------------

// File: rtl/dm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dm_arb_pkg
// Brief    : Shared state encoding, default widths and helpers for the
//            data-memory arbiters.
// Revision : 1.0
// ============================================================================
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam int c_DEF_ADDR_W = 8;
    localparam int c_DEF_DATA_W = 16;

    // Index width for a vector of 'value' entries; never narrower than 1 bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin pick: first set request at or after
//            'start', searching cyclically upward.
// Revision : 1.0
// ============================================================================
module rr_pick
    import dm_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] start,
    output logic [PTR_W-1:0] winner,
    output logic             any_req
);

    logic [2*N_REQ-1:0] w_req_dbl;
    logic [N_REQ-1:0]   w_req_rot;
    logic [PTR_W:0]     w_sum;

    // Doubling the vector turns the cyclic search into a plain shift.
    assign w_req_dbl = {req, req};
    assign w_req_rot = N_REQ'(w_req_dbl >> start);

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        w_sum   = '0;
        // Descending scan: the lowest rotated offset is assigned last and wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                any_req = 1'b1;
                w_sum   = {1'b0, start} + (PTR_W + 1)'(i);
                if (w_sum >= (PTR_W + 1)'(N_REQ)) begin
                    w_sum = w_sum - (PTR_W + 1)'(N_REQ);
                end
                winner = w_sum[PTR_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_arbiter
// Brief    : Round-robin arbiter sharing one single-port synchronous data
//            RAM among N_CORES matrix-multiplication cores.
// Revision : 1.0
// ============================================================================
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = c_DEF_ADDR_W,
    parameter int DATA_W  = c_DEF_DATA_W
) (
    input  logic                      clock,
    input  logic                      rst_n,
    input  logic [N_CORES-1:0]        core_req,
    input  logic [N_CORES-1:0]        core_we,
    input  logic [N_CORES*ADDR_W-1:0] core_addr,
    input  logic [N_CORES*DATA_W-1:0] core_wdata,
    output logic [N_CORES-1:0]        core_ack,
    output logic [DATA_W-1:0]         core_rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      busy
);

    localparam int                 c_PTR_W = clog2(N_CORES);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(N_CORES - 1);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [c_PTR_W-1:0]  r_rr_ptr;
    logic [c_PTR_W-1:0]  r_winner;
    logic [c_PTR_W-1:0]  w_pick;
    logic                w_any_req;

    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [N_CORES-1:0]  r_core_ack;
    logic                r_resp_rd;

    logic [ADDR_W-1:0]   w_addr_arr  [N_CORES];
    logic [DATA_W-1:0]   w_wdata_arr [N_CORES];

    for (genvar g = 0; g < N_CORES; g++) begin : g_unpack
        assign w_addr_arr[g]  = core_addr[g*ADDR_W +: ADDR_W];
        assign w_wdata_arr[g] = core_wdata[g*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N_REQ (N_CORES),
        .PTR_W (c_PTR_W)
    ) u_rr_pick (
        .req     (core_req),
        .start   (r_rr_ptr),
        .winner  (w_pick),
        .any_req (w_any_req)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Memory strobe and ack are single-cycle: cleared every cycle unless set below.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_winner    <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_core_ack  <= '0;
            r_resp_rd   <= 1'b0;
        end else begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_core_ack  <= '0;
            r_resp_rd   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_winner    <= w_pick;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= core_we[w_pick];
                        r_mem_addr  <= w_addr_arr[w_pick];
                        r_mem_wdata <= w_wdata_arr[w_pick];
                    end
                end
                ISSUE: begin
                    r_core_ack[r_winner] <= 1'b1;
                    r_resp_rd            <= ~r_mem_we;
                end
                RESP: begin
                    r_rr_ptr <= (r_winner == c_LAST) ? '0 : r_winner + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign core_ack   = r_core_ack;
    // The RAM's own output register is the capture stage; only gate it here.
    assign core_rdata = r_resp_rd ? mem_rdata : '0;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire
